// File: rtl/float_add_sub_seq.sv
// Multi-cycle IEEE-style floating-point adder/subtractor (IDLE/ALIGN/ADD/NORM/ROUND/DONE).
// Round-to-nearest-even, denormals flushed to zero, canonical NaN on invalid operations.
module float_add_sub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 execute,
   input  logic                 select,
   input  logic [EXP_W+MAN_W:0] A,
   input  logic [EXP_W+MAN_W:0] B,
   output logic [EXP_W+MAN_W:0] out,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 zero,
   output logic                 invalid
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 5;
   localparam int EW = EXP_W + 2;
   localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic [1:0] SP_NONE = 2'd0;
   localparam logic [1:0] SP_NAN  = 2'd1;
   localparam logic [1:0] SP_INF  = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

   state_t        state_q;
   logic [W-1:0]  a_q, b_q, res_q;
   logic          sign_q, sub_q, canc_q;
   logic [1:0]    spec_q;
   logic [EW-1:0] exp_q;
   logic [SW-1:0] big_q, small_q, sum_q, norm_q;
   logic [3:0]    flags_q;

   // Right shift keeping G/R and a sticky OR of everything shifted past R.
   function automatic logic [SW-1:0] align_f(input logic [SW-1:0] sig, input logic [EXP_W-1:0] d);
      logic [SW-1:0] sh;
      logic          lost;
      if ({{(32-EXP_W){1'b0}}, d} >= 32'(MAN_W + 3)) begin
         align_f = {{(SW-1){1'b0}}, |sig};
      end else begin
         sh      = sig >> d;
         lost    = |(sig & ~({SW{1'b1}} << d));
         align_f = {sh[SW-1:1], sh[0] | lost};
      end
   endfunction

   function automatic logic [EW-1:0] lzc_f(input logic [SW-1:0] v);
      logic          found;
      logic [EW-1:0] n;
      found = 1'b0;
      n     = {EW{1'b0}};
      for (int i = SW - 2; i >= 0; i--) begin
         if (found) begin
            n = n;
         end else if (v[i]) begin
            found = 1'b1;
         end else begin
            n = n + {{(EW-1){1'b0}}, 1'b1};
         end
      end
      return n;
   endfunction

   logic [EXP_W-1:0] ea_s, eb_s;
   logic [MAN_W-1:0] fa_s, fb_s;
   logic             a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s, a_big_s;
   logic [SW-1:0]    sig_a_s, sig_b_s;

   assign ea_s     = a_q[W-2:MAN_W];
   assign eb_s     = b_q[W-2:MAN_W];
   assign fa_s     = a_q[MAN_W-1:0];
   assign fb_s     = b_q[MAN_W-1:0];
   assign a_zero_s = (ea_s == {EXP_W{1'b0}});
   assign b_zero_s = (eb_s == {EXP_W{1'b0}});
   assign a_nan_s  = (&ea_s) & (|fa_s);
   assign b_nan_s  = (&eb_s) & (|fb_s);
   assign a_inf_s  = (&ea_s) & ~(|fa_s);
   assign b_inf_s  = (&eb_s) & ~(|fb_s);
   assign sig_a_s  = {1'b0, ~a_zero_s, a_zero_s ? {MAN_W{1'b0}} : fa_s, 3'b000};
   assign sig_b_s  = {1'b0, ~b_zero_s, b_zero_s ? {MAN_W{1'b0}} : fb_s, 3'b000};
   assign a_big_s  = {ea_s, sig_a_s} >= {eb_s, sig_b_s};

   logic          sign_d;
   logic [EW-1:0] exp_d;
   logic [SW-1:0] big_d, small_d;
   logic [1:0]    spec_d;

   // ALIGN: pick the larger magnitude and align the smaller significand to it.
   always_comb begin
      if (a_big_s) begin
         sign_d  = a_q[W-1];
         exp_d   = {2'b00, ea_s};
         big_d   = sig_a_s;
         small_d = align_f(sig_b_s, ea_s - eb_s);
      end else begin
         sign_d  = b_q[W-1];
         exp_d   = {2'b00, eb_s};
         big_d   = sig_b_s;
         small_d = align_f(sig_a_s, eb_s - ea_s);
      end
      if (a_nan_s | b_nan_s | (a_inf_s & b_inf_s & (a_q[W-1] ^ b_q[W-1]))) begin
         spec_d = SP_NAN;
      end else if (a_inf_s | b_inf_s) begin
         spec_d = SP_INF;
      end else begin
         spec_d = SP_NONE;
      end
   end

   logic [SW-1:0] sum_d, norm_d;
   logic [EW-1:0] lz_s, exp_n_d;
   logic          canc_d;

   // ADD and NORM datapaths.
   always_comb begin
      if (sub_q) begin
         sum_d = big_q - small_q;
      end else begin
         sum_d = big_q + small_q;
      end
      lz_s   = lzc_f(sum_q);
      canc_d = (sum_q == {SW{1'b0}});
      if (sum_q[SW-1]) begin
         norm_d  = {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
         exp_n_d = exp_q + {{(EW-1){1'b0}}, 1'b1};
      end else begin
         norm_d  = sum_q << lz_s;
         exp_n_d = exp_q - lz_s;
      end
   end

   logic             rnd_up_s;
   logic [MAN_W+1:0] man_r_s;
   logic [EW-1:0]    exp_r_s;
   logic [MAN_W-1:0] frac_r_s;
   logic [W-1:0]     res_d;
   logic [3:0]       flags_d;

   // ROUND: nearest-even, renormalise on mantissa carry, then resolve specials and range.
   always_comb begin
      rnd_up_s = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
      man_r_s  = {norm_q[SW-1], norm_q[SW-2:3]} + {{(MAN_W+1){1'b0}}, rnd_up_s};
      if (man_r_s[MAN_W+1]) begin
         exp_r_s  = exp_q + {{(EW-1){1'b0}}, 1'b1};
         frac_r_s = man_r_s[MAN_W:1];
      end else begin
         exp_r_s  = exp_q;
         frac_r_s = man_r_s[MAN_W-1:0];
      end
      if (spec_q == SP_NAN) begin
         res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         flags_d = 4'b0001;
      end else if (spec_q == SP_INF) begin
         res_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d = 4'b0000;
      end else if (canc_q) begin
         res_d   = {W{1'b0}};
         flags_d = 4'b0010;
      end else if (exp_r_s[EW-1] || (exp_r_s == {EW{1'b0}})) begin
         res_d   = {W{1'b0}};
         flags_d = 4'b0110;
      end else if (exp_r_s >= EXP_MAX) begin
         res_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d = 4'b1000;
      end else begin
         res_d   = {sign_q, exp_r_s[EXP_W-1:0], frac_r_s};
         flags_d = 4'b0000;
      end
   end

   // Sequencer, pipeline registers and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         a_q       <= {W{1'b0}};
         b_q       <= {W{1'b0}};
         res_q     <= {W{1'b0}};
         sign_q    <= 1'b0;
         sub_q     <= 1'b0;
         canc_q    <= 1'b0;
         spec_q    <= SP_NONE;
         exp_q     <= {EW{1'b0}};
         big_q     <= {SW{1'b0}};
         small_q   <= {SW{1'b0}};
         sum_q     <= {SW{1'b0}};
         norm_q    <= {SW{1'b0}};
         flags_q   <= 4'b0000;
         out       <= {W{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         zero      <= 1'b0;
         invalid   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (execute) begin
                  a_q       <= A;
                  b_q       <= {B[W-1] ^ select, B[W-2:0]};
                  busy      <= 1'b1;
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
                  zero      <= 1'b0;
                  invalid   <= 1'b0;
                  state_q   <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               sign_q  <= sign_d;
               exp_q   <= exp_d;
               big_q   <= big_d;
               small_q <= small_d;
               sub_q   <= a_q[W-1] ^ b_q[W-1];
               spec_q  <= spec_d;
               state_q <= S_ADD;
            end
            S_ADD: begin
               sum_q   <= sum_d;
               state_q <= S_NORM;
            end
            S_NORM: begin
               norm_q  <= norm_d;
               exp_q   <= exp_n_d;
               canc_q  <= canc_d;
               state_q <= S_ROUND;
            end
            S_ROUND: begin
               res_q   <= res_d;
               flags_q <= flags_d;
               state_q <= S_DONE;
            end
            S_DONE: begin
               out       <= res_q;
               {overflow, underflow, zero, invalid} <= flags_q;
               done      <= 1'b1;
               busy      <= 1'b0;
               state_q   <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/float_add_sub_seq.md
FLOAT_ADD_SUB_SEQ -- requirements
Module: float_add_sub_seq

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning stored fraction width (hidden bit excluded); word width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port execute  in  1  start request, sampled only in IDLE.
REQ-006 The block SHALL have port select  in  1  0 = A+B, 1 = A-B; sampled with execute.
REQ-007 The block SHALL have ports A and B  in  W  IEEE-style operands {sign, exponent, fraction}; sampled with execute.
REQ-008 The block SHALL have port out  out  W  result, held until the next completion.
REQ-009 The block SHALL have port busy  out  1  high from the capture edge until done.
REQ-010 The block SHALL have port done  out  1  one-cycle pulse marking out and flags valid.
REQ-011 The block SHALL have ports overflow, underflow, zero, invalid  out  1 each  status flags, updated with done.

Function
REQ-012 FSM states SHALL be IDLE, ALIGN, ADD, NORM, ROUND, DONE, advancing one state per clock; DONE returns to IDLE.
REQ-013 In IDLE, execute=1 at a rising edge SHALL capture A, B and select, set busy and enter ALIGN; B's sign is inverted when select=1.
REQ-014 execute SHALL be ignored while busy=1, with no effect on the operation in flight.
REQ-015 done SHALL assert exactly 5 edges after the capture edge, for exactly one cycle; busy SHALL deassert on the same edge; back-to-back operations SHALL be accepted on the cycle done is high.
REQ-016 ALIGN: the operand with the larger magnitude (exponent, then fraction) SHALL be selected; the smaller significand SHALL be right-shifted by the exponent difference, keeping guard, round and sticky bits (sticky = OR of all bits shifted past round); shifts >= MAN_W+3 SHALL yield only the sticky bit.
REQ-017 ADD: the significand path SHALL be MAN_W+5 bits (carry, hidden, fraction, G, R, S); effective signs equal -> add, else subtract smaller from larger; result sign = sign of the larger-magnitude operand.
REQ-018 NORM: on carry-out, shift right 1 (folding the lost bit into sticky) and increment the exponent; otherwise shift left by the leading-zero count (0 to MAN_W+1) in one cycle and decrement the exponent by that count.
REQ-019 ROUND: round-to-nearest-even on G/R/S; a mantissa carry from rounding SHALL renormalise and increment the exponent.
REQ-020 An exponent field of 0 SHALL be treated as zero (denormals flushed); a zero operand SHALL pass the other operand through unchanged.
REQ-021 An exact cancellation result SHALL be +0 with zero=1.
REQ-022 A final biased exponent >= 2^EXP_W-1 SHALL give a signed infinity with overflow=1; one <= 0 SHALL give +0 with underflow=1 and zero=1.
REQ-023 Any NaN input, or infinity minus infinity of the same magnitude, SHALL give canonical NaN {0, all-ones exponent, MSB-only fraction} with invalid=1; a single infinity input SHALL pass through with its effective sign.
REQ-024 Flags SHALL be cleared at each capture edge and set only at the DONE transition.

Reset
REQ-025 reset low SHALL immediately, without a clock, force IDLE with out=0, busy=0, done=0 and all flags 0, including mid-operation.
REQ-026 After reset release, the first accepted execute SHALL behave exactly as from power-up; no partial result SHALL ever appear on out.

Verification
REQ-027 0x3F800000 + 0x3F800000, select=0 -> out=0x40000000, done exactly 5 edges after capture, all flags 0.
REQ-028 0x3FC00000 - 0x3FC00000, select=1 -> out=0x00000000, zero=1.
REQ-029 0x3F800000 - 0x3F7FFFFF -> out=0x33800000 (multi-bit left normalisation).
REQ-030 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even); 0x3F800000 + 0x33800001 -> 0x3F800001.
REQ-031 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1; 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1.
REQ-032 Drive reset low at the edge after capture, release, then issue a new execute with execute also held high during busy -> out=0 and done=0 during reset; only the new operation completes, 5 edges after its capture.
